// File: rtl/fp_sum_result_queue_pkg.sv
// ============================================================================
// Module : fp_sum_result_queue_pkg
// Brief  : Shared types for the FP summator result queue (float value, FIFO entry).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fp_sum_result_queue_pkg;

    localparam int FP_W     = 32;
    localparam int STATUS_W = 2;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mant;
    } float_point_num;

    typedef struct packed {
        logic [STATUS_W-1:0] status;
        float_point_num      val;
    } fp_res_entry_t;

    function automatic fp_res_entry_t make_entry(input logic [STATUS_W-1:0] st,
                                                 input float_point_num      v);
        fp_res_entry_t e;
        e.status = st;
        e.val    = v;
        return e;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fp_sum_result_queue_if.sv
// ============================================================================
// Module : fp_sum_result_queue_if
// Brief  : Issue, summator-answer and result handshake bundle for the result queue.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface fp_sum_result_queue_if
    import fp_sum_result_queue_pkg::*;
#(
    parameter int DEPTH = 8
) ();

    localparam int LVL_W = $clog2(DEPTH + 1);

    logic                vld_i;
    logic                issue_rdy_o;
    float_point_num      answer_i;
    logic [STATUS_W-1:0] num_status_i;
    logic                res_vld_o;
    logic                res_rdy_i;
    float_point_num      res_o;
    logic [STATUS_W-1:0] res_status_o;
    logic [LVL_W-1:0]    level_o;
    logic                overflow_o;

    // Queue side
    modport master (
        input  vld_i, answer_i, num_status_i, res_rdy_i,
        output issue_rdy_o, res_vld_o, res_o, res_status_o, level_o, overflow_o
    );

    // Issuer / summator / consumer side
    modport slave (
        output vld_i, answer_i, num_status_i, res_rdy_i,
        input  issue_rdy_o, res_vld_o, res_o, res_status_o, level_o, overflow_o
    );

endinterface

`default_nettype wire

// File: rtl/fp_sum_result_queue_fifo.sv
// ============================================================================
// Module : fp_res_fifo
// Brief  : DEPTH-entry synchronous in-order FIFO of fp_res_entry_t; rdata is zero when empty.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_res_fifo
    import fp_sum_result_queue_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  wire logic             clk_i,
    input  wire logic             rst_i,
    input  wire logic             push,
    input  wire logic             pop,
    input  wire fp_res_entry_t    wdata,
    output fp_res_entry_t         rdata,
    output logic [LVL_W-1:0]      level,
    output logic                  full,
    output logic                  empty
);

    fp_res_entry_t      mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level_q;
    logic               do_push;
    logic               do_pop;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign do_pop  = pop & ~empty;
    // A push at full only lands when the same cycle frees a slot
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/fp_sum_result_queue.sv
// ============================================================================
// Module : fp_sum_result_queue
// Brief  : Tracks ops issued to a fixed-latency FP summator and queues {status, answer}
//          in order behind a valid/ready port, with credit-based issue_rdy_o.
//          Optional macro FP_RESQ_BYPASS_EN: empty-queue answers bypass straight to res_o.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fp_sum_result_queue
    import fp_sum_result_queue_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  wire logic               clk_i,
    input  wire logic               rst_i,
    fp_sum_result_queue_if.master   bus
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int CNT_W = $clog2(LATENCY + 1);
    localparam int SUM_W = ((CNT_W > LVL_W) ? CNT_W : LVL_W) + 1;

`ifdef FP_RESQ_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [LATENCY-1:0] dly_q;
    logic               tap;
    logic [CNT_W-1:0]   inflight_q;
    logic               overflow_q;
    logic [SUM_W-1:0]   committed;

    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [LVL_W-1:0]   fifo_level;
    fp_res_entry_t      head;
    fp_res_entry_t      wentry;
    fp_res_entry_t      res_ent;
    logic               res_vld;

    // Valid delay line mirroring the summator pipeline
    generate
        if (LATENCY == 1) begin : g_dly_one
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= bus.vld_i;
                end
            end
        end else begin : g_dly_multi
            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    dly_q <= '0;
                end else begin
                    dly_q <= {dly_q[LATENCY-2:0], bus.vld_i};
                end
            end
        end
    endgenerate

    assign tap = dly_q[LATENCY-1];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            inflight_q <= '0;
        end else begin
            case ({bus.vld_i, tap})
                2'b10:   inflight_q <= inflight_q + CNT_W'(1);
                2'b01:   inflight_q <= inflight_q - CNT_W'(1);
                default: inflight_q <= inflight_q;
            endcase
        end
    end

    // Credit covers every op that will eventually need a slot; pops are credited next cycle
    assign committed       = SUM_W'(inflight_q) + SUM_W'(fifo_level);
    assign bus.issue_rdy_o = (committed < SUM_W'(DEPTH));

    assign wentry = make_entry(bus.num_status_i, bus.answer_i);

    always_comb begin
        res_vld   = ~fifo_empty;
        res_ent   = head;
        fifo_push = tap;
        fifo_pop  = ~fifo_empty & bus.res_rdy_i;
        if (BYPASS && fifo_empty && tap) begin
            res_vld   = 1'b1;
            res_ent   = wentry;
            fifo_push = ~bus.res_rdy_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            overflow_q <= 1'b0;
        end else if (tap && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    fp_res_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wentry),
        .rdata (head),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign bus.res_vld_o    = res_vld;
    assign bus.res_o        = res_ent.val;
    assign bus.res_status_o = res_ent.status;
    assign bus.level_o      = fifo_level;
    assign bus.overflow_o   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fp_sum_result_queue.sv
// ============================================================================
// Module : tb_fp_sum_result_queue
// Brief  : Scoreboard bench for fp_sum_result_queue with a fixed-latency summator model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fp_sum_result_queue;

    localparam int L = 4;
    localparam int D = 8;
`ifdef FP_RESQ_BYPASS_EN
    localparam int EXP_LAT = 4;
`else
    localparam int EXP_LAT = 5;
`endif

    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    fp_sum_result_queue_if #(.DEPTH(D)) bus ();

    fp_sum_result_queue #(.LATENCY(L), .DEPTH(D)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    logic [33:0] exp_q[$];

    // Summator model: answer for an op shows up L edges after its vld_i sample
    logic [31:0] op_ans = '0;
    logic [1:0]  op_st  = '0;
    logic [L-1:0] s_vld;
    logic [31:0] s_ans [L];
    logic [1:0]  s_st  [L];

    always @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            s_vld <= '0;
        end else begin
            s_vld    <= {s_vld[L-2:0], bus.vld_i};
            s_ans[0] <= op_ans;
            s_st[0]  <= op_st;
            for (int i = 1; i < L; i++) begin
                s_ans[i] <= s_ans[i-1];
                s_st[i]  <= s_st[i-1];
            end
        end
    end

    assign bus.answer_i     = s_vld[L-1] ? s_ans[L-1] : 32'hDEADBEEF;
    assign bus.num_status_i = s_vld[L-1] ? s_st[L-1]  : 2'b11;

    always @(negedge clk) begin
        if (rst_i && bus.res_vld_o && bus.res_rdy_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_result got=%h required=none", {bus.res_status_o, bus.res_o});
            end else begin
                logic [33:0] e;
                e = exp_q.pop_front();
                if ({bus.res_status_o, bus.res_o} !== e) begin
                    n_bad++;
                    $display("FAIL result_order got=%h required=%h", {bus.res_status_o, bus.res_o}, e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic [31:0] a, input logic [1:0] s, input bit expect_push);
        bus.vld_i = 1'b1;
        op_ans    = a;
        op_st     = s;
        if (expect_push) exp_q.push_back({s, a});
    endtask

    logic [31:0] fill_ans [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                  32'h40A00000, 32'hC0000000, 32'h7F800000, 32'h00000000};
    logic [1:0]  fill_st  [8] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd3, 2'd1};
    logic [31:0] strm_ans [6] = '{32'h41200000, 32'hBF000000, 32'h3E800000,
                                  32'h42C80000, 32'hFF800000, 32'h7FC00000};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int issued;
        int vhigh;
        bus.vld_i     = 1'b0;
        bus.res_rdy_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("por_res_vld", bus.res_vld_o, 0);
        chk("por_issue_rdy", bus.issue_rdy_o, 1);
        chk("por_level", bus.level_o, 0);
        step();
        rst_i = 1'b1;
        step();

        // Single op latency
        bus.res_rdy_i = 1'b1;
        drive_op(32'h40400000, 2'b00, 1'b1);
        step();
        bus.vld_i = 1'b0;
        for (int k = 1; k <= EXP_LAT + 1; k++) begin
            if (k > 1) @(posedge clk);
            @(negedge clk);
            if (k == EXP_LAT - 1) chk("single_before", bus.res_vld_o, 0);
            if (k == EXP_LAT)     chk("single_at", bus.res_vld_o, 1);
            if (k == EXP_LAT + 1) chk("single_after", bus.res_vld_o, 0);
        end
        step();

        // Fill with consumer stalled
        bus.res_rdy_i = 1'b0;
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.issue_rdy_o) begin
                if (issued < 8) drive_op(fill_ans[issued], fill_st[issued], 1'b1);
                else            drive_op(32'h41000000 + issued, 2'd0, 1'b1);
                issued++;
            end else begin
                bus.vld_i = 1'b0;
            end
            step();
        end
        bus.vld_i = 1'b0;
        chk("fill_issues", issued, 8);
        @(negedge clk);
        chk("fill_level", bus.level_o, 8);
        chk("fill_issue_rdy", bus.issue_rdy_o, 0);
        chk("fill_overflow", bus.overflow_o, 0);
        chk("fill_head", {bus.res_status_o, bus.res_o}, {2'd0, 32'h3F800000});
        step();

        // Forced issue against a full queue
        drive_op(32'hBF800000, 2'd1, 1'b0);
        step();
        bus.vld_i = 1'b0;
        repeat (L + 1) step();
        @(negedge clk);
        chk("viol_overflow", bus.overflow_o, 1);
        chk("viol_level", bus.level_o, 8);
        chk("viol_head", {bus.res_status_o, bus.res_o}, {2'd0, 32'h3F800000});
        step();

        // Drain in order; credit returns one cycle after the first pop
        bus.res_rdy_i = 1'b1;
        @(negedge clk);
        chk("drain_no_same_cycle_credit", bus.issue_rdy_o, 0);
        step();
        @(negedge clk);
        chk("drain_credit_back", bus.issue_rdy_o, 1);
        chk("drain_level7", bus.level_o, 7);
        for (int c = 0; c < 16 && bus.level_o != 0; c++) step();
        @(negedge clk);
        chk("drain_level0", bus.level_o, 0);
        chk("drain_res_zero", {bus.res_vld_o, bus.res_status_o, bus.res_o}, 0);
        chk("drain_overflow_sticky", bus.overflow_o, 1);
        step();

        // Streaming with intermittent backpressure
        for (int c = 0; c < 24; c++) begin
            bus.res_rdy_i = (c % 3) != 0;
            if (c < 6 && bus.issue_rdy_o) drive_op(strm_ans[c], 2'(c), 1'b1);
            else                          bus.vld_i = 1'b0;
            step();
        end
        bus.vld_i = 1'b0;
        bus.res_rdy_i = 1'b1;
        repeat (4) step();
        chk("stream_drained", exp_q.size(), 0);

        // Mid-run reset with results queued
        bus.res_rdy_i = 1'b0;
        drive_op(32'h40E00000, 2'd2, 1'b1);
        step();
        drive_op(32'h41100000, 2'd1, 1'b1);
        step();
        bus.vld_i = 1'b0;
        repeat (L + 2) step();
        rst_i = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("rst_res", {bus.res_vld_o, bus.res_status_o, bus.res_o}, 0);
        chk("rst_level", bus.level_o, 0);
        chk("rst_issue_rdy", bus.issue_rdy_o, 1);
        chk("rst_overflow", bus.overflow_o, 0);
        step();
        rst_i = 1'b1;
        step();

        // Reset with three ops in flight
        bus.res_rdy_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            drive_op(32'h3F000000 + c, 2'd0, 1'b0);
            step();
        end
        bus.vld_i = 1'b0;
        rst_i = 1'b0;
        step();
        rst_i = 1'b1;
        vhigh = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.res_vld_o) vhigh++;
            step();
        end
        chk("inflight_rst_no_vld", vhigh, 0);
        @(negedge clk);
        chk("inflight_rst_level", bus.level_o, 0);
        chk("final_sb_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
